timer_display_driver: RTL and testbench
=======================================

# timer_display_driver

Consumer side of the `Timer` digit interface. Takes the `minutes0`/`seconds1`/`seconds0` BCD digits and the `count` run flag, and drives a 3-digit multiplexed common-anode 7-segment display. It captures the digits once per scan frame so the display never tears, blanks each digit slot briefly to stop ghosting, and blinks the whole display while the timer is paused (`count = 0`).

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `BLINK_FRAMES`, default 32: scan frames per blink half-period. Must be ≥ 1.

Ports (one clock; `reset` is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `count`  in  1  timer run flag. 1 = running (steady display), 0 = paused (blink).
- `minutes0`  in  4  BCD minutes digit.
- `seconds1`  in  4  BCD tens-of-seconds digit.
- `seconds0`  in  4  BCD seconds digit.
- `an`  out  3  anode enables, active-low. `an[0]` = seconds0, `an[1]` = seconds1, `an[2]` = minutes0.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low. Used as the minutes/seconds separator.
- `frame`  out  1  one-cycle pulse on the last cycle of each scan frame.

## Operation
- State:
  - `div_cnt`: 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - `idx`: 0..2, the current digit slot.
  - `snap`: 12-bit digit snapshot.
  - `blink`: 1 bit.
  - `blink_cnt`: 0..BLINK_FRAMES-1.
- Scan:
  - `div_cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances 0→1→2→0.
  - One frame = 3·REFRESH_DIV cycles.
- Frame end: the cycle with `idx`=2 and `div_cnt`=REFRESH_DIV-1.
  - `frame`=1 in that cycle.
  - On the closing edge, `snap` captures {minutes0, seconds1, seconds0}.
- Snapshot: inputs are sampled only at frame end. Input changes mid-frame are invisible until the next frame.
- Blink:
  - If `count`=1: next edge clears `blink` and `blink_cnt`.
  - If `count`=0, at each frame end: when `blink_cnt`=BLINK_FRAMES-1, toggle `blink` and clear `blink_cnt`; otherwise increment `blink_cnt`.
  - A partial frame in which `count` fell still counts.
- Output function:
  - If `div_cnt`=0 (anti-ghost blank) or `blink`=1: `an`=3'b111, `seg`=7'h7F, `dp`=1.
  - Otherwise: `an` has a single 0 at bit `idx`, and `seg` = decode(`snap` digit `idx`).
  - `dp`=0 only when `idx`=2 and the digit is not blanked.
- Decode (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values 10–15 show a dash, 3F.
- `count` is synchronous to `clk` and is not resynchronized.

## Timing
- Reset values:
  - State: `div_cnt`=0, `idx`=0, `snap`=0, `blink`=0, `blink_cnt`=0.
  - Outputs: `an`=3'b111, `seg`=7'h7F, `dp`=1, `frame`=0.
- Outputs are registered. They are loaded from next-state on the same edge that updates state, so in any cycle `an`/`seg`/`dp`/`frame` equal the output function of that cycle's state. No combinational path runs from inputs to outputs.
- The first frame after reset displays `snap`=0 ("0.00"). Live inputs appear from the second frame.
- Per slot: 1 blank cycle, then REFRESH_DIV-1 lit cycles.
- `frame` period is exactly 3·REFRESH_DIV cycles, independent of `count` and `blink`.
- Reset mid-frame or mid-blink returns all state and outputs to reset values on that edge. Reset has priority over all other events.
- `count` rising during the blank half: the display is lit from the next cycle whose `div_cnt`≠0. `blink_cnt` restarts from 0 on the next pause.

## Test plan
Bench parameters: REFRESH_DIV=4, BLINK_FRAMES=2, 10 ns clock.
1. Reset held 3 cycles, then released with inputs 0 → `an`=111, `seg`=7F, `dp`=1, `frame`=0 while in reset. After release: cycle 0 `an`=111; cycles 1–3 `an`=110, `seg`=40; `frame`=1 in cycle 11 only.
2. Inputs 3:47, `count`=1 → in the second frame: slot0 `an`=110, `seg`=78; slot1 `an`=101, `seg`=19; slot2 `an`=011, `seg`=30, `dp`=0. Each slot's first cycle has `an`=111.
3. Change `seconds0` 7→8 in cycle 5 of a frame → slot0 keeps showing 78 for the rest of that frame and shows 00 from the next frame.
4. `seconds1`=4'hC → slot1 `seg`=3F.
5. `count`=0 from a frame start → 2 frames lit, then 24 cycles with `an`=111, then lit again. `frame` pulses continue every 12 cycles. Setting `count`=1 during the blank half → lit from the next non-blank cycle.
6. Reset asserted mid-frame while `blink`=1 → next edge gives `an`=111, `seg`=7F, `frame`=0. After release, the scan restarts at `idx`=0 and shows 0.00.

Source files
------------

// File: rtl/timer_display_driver.sv
// 3-digit multiplexed 7-seg driver: frame-synchronous digit snapshot, per-slot blanking, pause blink.
// Registered outputs reflect current state (no input-to-output path); no backpressure, free-running scan.
module timer_display_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic [3:0] minutes0,
    input  logic [3:0] seconds1,
    input  logic [3:0] seconds0,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [DW-1:0] div_cnt, div_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [11:0]   snap, snap_nxt;
    logic          blink, blink_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;

    logic          frame_end;
    logic          blank_nxt;
    logic [3:0]    digit_nxt;
    logic [2:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          frame_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Next-state of the scan, snapshot and blink machinery.
    always_comb begin
        frame_end     = (idx == 2'd2) && (div_cnt == DIV_LAST);
        div_nxt       = div_cnt + DW'(1);
        idx_nxt       = idx;
        snap_nxt      = snap;
        blink_nxt     = blink;
        blink_cnt_nxt = blink_cnt;

        if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end

        if (frame_end)
            snap_nxt = {minutes0, seconds1, seconds0};

        if (count) begin
            blink_nxt     = 1'b0;
            blink_cnt_nxt = '0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_nxt     = ~blink;
                blink_cnt_nxt = '0;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end
    end

    // Output function evaluated on next state so the registered outputs line up with state.
    always_comb begin
        blank_nxt = (div_nxt == '0) || blink_nxt;
        case (idx_nxt)
            2'd0:    digit_nxt = snap_nxt[3:0];
            2'd1:    digit_nxt = snap_nxt[7:4];
            default: digit_nxt = snap_nxt[11:8];
        endcase
        an_nxt    = 3'b111;
        seg_nxt   = 7'h7F;
        dp_nxt    = 1'b1;
        frame_nxt = (idx_nxt == 2'd2) && (div_nxt == DIV_LAST);
        if (!blank_nxt) begin
            an_nxt  = ~(3'b001 << idx_nxt);
            seg_nxt = decode(digit_nxt);
            dp_nxt  = (idx_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            idx       <= 2'd0;
            snap      <= 12'h000;
            blink     <= 1'b0;
            blink_cnt <= '0;
            an        <= 3'b111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            frame     <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            idx       <= idx_nxt;
            snap      <= snap_nxt;
            blink     <= blink_nxt;
            blink_cnt <= blink_cnt_nxt;
            an        <= an_nxt;
            seg       <= seg_nxt;
            dp        <= dp_nxt;
            frame     <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_timer_display_driver.sv
// Directed bench for timer_display_driver with REFRESH_DIV=4, BLINK_FRAMES=2 (12-cycle frames).
module tb_timer_display_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       count;
    logic [3:0] minutes0, seconds1, seconds0;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    timer_display_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .count(count),
        .minutes0(minutes0), .seconds1(seconds1), .seconds0(seconds0),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // Expected outputs for cycle c (0..11) of a frame showing digits {m0,s1,s0}.
    function automatic exp_t frame_exp(input int c, input logic [11:0] digits, input logic blank);
        exp_t e;
        int slot = c / 4;
        logic [3:0] d = digits[slot*4 +: 4];
        e.frame = (c == 11);
        if (blank || (c % 4) == 0) begin
            e.an = 3'b111; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
            e.an  = ~(3'b001 << slot);
            e.seg = seg_ref(d);
            e.dp  = (slot != 2);
        end
        return e;
    endfunction

    task automatic compare(input string tag, input int c);
        exp_t e, o;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s c%0d: scoreboard empty", tag, c);
            return;
        end
        e = exp_q.pop_front();
        o = '{an: an, seg: seg, dp: dp, frame: frame};
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s c%0d: observed an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=%b",
                   tag, c, o.an, o.seg, o.dp, o.frame, e.an, e.seg, e.dp, e.frame);
        end
    endtask

    // Called positioned at the negedge of cycle c_from; leaves positioned at cycle c_to+1.
    task automatic check_cycles(input string tag, input logic [11:0] digits, input logic blank,
                                input int c_from, input int c_to);
        for (int c = c_from; c <= c_to; c++)
            exp_q.push_back(frame_exp(c, digits, blank));
        for (int c = c_from; c <= c_to; c++) begin
            compare(tag, c);
            @(negedge clk);
        end
    endtask

    task automatic check_reset(input string tag);
        exp_q.push_back('{an: 3'b111, seg: 7'h7F, dp: 1'b1, frame: 1'b0});
        compare(tag, 0);
    endtask

    initial begin
        reset = 1'b1; count = 1'b1;
        minutes0 = 4'd0; seconds1 = 4'd0; seconds0 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        // Current cycle holds the reset state: cycle 0 of the first frame.
        reset = 1'b0;
        minutes0 = 4'd3; seconds1 = 4'd4; seconds0 = 4'd7;
        check_cycles("frame1_zero", 12'h000, 1'b0, 0, 11);

        check_cycles("live_347", 12'h347, 1'b0, 0, 4);
        seconds0 = 4'd8; seconds1 = 4'hC;
        check_cycles("midframe_hold", 12'h347, 1'b0, 5, 11);
        check_cycles("new_3C8", 12'h3C8, 1'b0, 0, 11);

        count = 1'b0;
        check_cycles("pause_lit1", 12'h3C8, 1'b0, 0, 11);
        check_cycles("pause_lit2", 12'h3C8, 1'b0, 0, 11);
        check_cycles("blink_off1", 12'h3C8, 1'b1, 0, 11);
        check_cycles("blink_off2", 12'h3C8, 1'b1, 0, 11);
        check_cycles("blink_on1", 12'h3C8, 1'b0, 0, 11);
        check_cycles("blink_on2", 12'h3C8, 1'b0, 0, 11);
        check_cycles("blink_off3", 12'h3C8, 1'b1, 0, 3);
        count = 1'b1;
        check_cycles("resume", 12'h3C8, 1'b0, 4, 11);
        check_cycles("running", 12'h3C8, 1'b0, 0, 11);

        count = 1'b0;
        check_cycles("pause2_lit1", 12'h3C8, 1'b0, 0, 11);
        check_cycles("pause2_lit2", 12'h3C8, 1'b0, 0, 11);
        check_cycles("pause2_off", 12'h3C8, 1'b1, 0, 9);
        reset = 1'b1;
        @(negedge clk);
        check_reset("reset_midblink");
        reset = 1'b0;
        check_cycles("after_reset", 12'h000, 1'b0, 0, 11);
        check_cycles("after_reset_live", 12'h3C8, 1'b0, 0, 11);

        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
